trk_lock_det: RTL
=================

TRK_LOCK_DET -- requirements
Module: trk_lock_det

Interface
REQ-001 Parameter ACC_W, default 24, is the width of the signed prompt accumulator inputs.
REQ-002 Parameter N_INT, default 20, is the number of integrations per test window (2..255).
REQ-003 Parameter RATIO_SH, default 1; a window passes when sumI > (sumQ << RATIO_SH).
REQ-004 Parameter LOCK_CNT, default 3, is the number of consecutive passing windows required to declare lock (1..15).
REQ-005 Parameter FAIL_CNT, default 2, is the number of consecutive failing windows, while locked, that declares loss of lock (1..15).
REQ-006 Parameter TMO_WIN, default 50, is the number of windows allowed in SEARCH before a timeout (1..255).
REQ-007 rx_clk  in  1  system clock; all logic is on the rising edge.
REQ-008 rx_rst  in  1  asynchronous, active-low reset.
REQ-009 rx_restart  in  1  synchronous active-high pulse issued by acquisition at tracking handover.
REQ-010 rx_acc_real  in  ACC_W  signed prompt I accumulation.
REQ-011 rx_acc_imag  in  ACC_W  signed prompt Q accumulation.
REQ-012 rx_acc_vld  in  1  one-cycle strobe; the accumulation inputs are valid when it is high.
REQ-013 tx_lock  out  1  registered lock flag.
REQ-014 tx_state  out  2  current state: 0 = SEARCH, 1 = LOCKED, 2 = LOST.
REQ-015 tx_reacq_req  out  1  one-cycle pulse requesting reacquisition.
REQ-016 tx_win_cnt  out  8  number of windows evaluated since the last restart, saturating at 255.

Function
REQ-017 The absolute value of each input shall saturate: |-2^(ACC_W-1)| yields 2^(ACC_W-1)-1.
REQ-018 On each rx_acc_vld, sumI shall accumulate |I| and sumQ shall accumulate |Q|, each ACC_W+8 bits wide, so no overflow is possible at N_INT ≤ 255.
REQ-019 A sample counter shall count accepted vld strobes; the N_INT-th strobe completes the window and sets the registered flag win_done for exactly one cycle.
REQ-020 In the win_done cycle, the pass/fail compare (REQ-003) shall use the final sums, and state and counters shall update on that cycle's closing edge, so outputs change on the 2nd rising edge after the edge sampling the final vld.
REQ-021 In the win_done cycle, the sums and sample counter shall clear; a vld coincident with win_done shall be loaded as sample 1 of the new window and not lost.
REQ-022 SEARCH: a pass increments pass_cnt and a fail clears it; pass_cnt reaching LOCK_CNT moves the block to LOCKED, sets tx_lock and clears tmo_cnt.
REQ-023 SEARCH: each window increments tmo_cnt; tmo_cnt reaching TMO_WIN without lock moves the block to LOST.
REQ-024 LOCKED: a fail increments fail_cnt and a pass clears it; fail_cnt reaching FAIL_CNT moves the block to LOST and clears tx_lock on the same edge.
REQ-025 LOST: tx_reacq_req shall pulse high for the single cycle in which tx_state first shows 2; the block then holds in LOST, ignoring vld and keeping the sums at zero, until rx_restart.
REQ-026 rx_restart, in any state, shall on the next edge clear the sums, all counters, tx_win_cnt, tx_lock and tx_reacq_req, and select SEARCH.
REQ-027 rx_restart coincident with vld or win_done shall take priority; the sample and the window result are discarded.
REQ-028 tx_win_cnt shall increment on each win_done and hold at 255.

Reset
REQ-029 While rx_rst = 0, asynchronously: tx_lock = 0, tx_state = 0 (SEARCH), tx_reacq_req = 0, tx_win_cnt = 0, and all sums, counters and win_done are zero.
REQ-030 Upon release of rx_rst, the first vld sampled shall be sample 1 of window 1.

Verification (bench parameters: ACC_W = 16, N_INT = 4, RATIO_SH = 1, LOCK_CNT = 3, FAIL_CNT = 2, TMO_WIN = 8)
REQ-031 12 vld with I = 1000, Q = 100 -> tx_lock = 1 and tx_state = 1 two edges after the 12th vld; tx_win_cnt = 3.
REQ-032 From lock, 8 vld with I = 100, Q = 1000 -> tx_state = 2, tx_lock = 0, and one tx_reacq_req pulse two edges after the 8th vld.
REQ-033 32 vld with I = 300, Q = 200 (a fail, since 1200 ≤ 1600) -> LOST and a reacq pulse after window 8; further vld leave the sums at zero.
REQ-034 I = -32768, Q = 0 every cycle -> sumI per window = 131068 with no wrap; the block locks.
REQ-035 Vld on every cycle, including win_done cycles -> no samples dropped; windows evaluated exactly every 4 vld.
REQ-036 rx_restart coincident with the 4th vld of a passing window -> the window is not counted; tx_win_cnt = 0 and the state is SEARCH; asserting rx_rst mid-window clears all outputs immediately, without a clock edge.

Source files
------------

// File: rtl/trk_lock_det.sv
// Tracking lock detector: integrates |I| and |Q| over N_INT prompt samples and
// runs a SEARCH / LOCKED / LOST decision on each completed window.
module trk_lock_det #(
    parameter int ACC_W    = 24,
    parameter int N_INT    = 20,
    parameter int RATIO_SH = 1,
    parameter int LOCK_CNT = 3,
    parameter int FAIL_CNT = 2,
    parameter int TMO_WIN  = 50
) (
    input  logic                    rx_clk,
    input  logic                    rx_rst,
    input  logic                    rx_restart,
    input  logic signed [ACC_W-1:0] rx_acc_real,
    input  logic signed [ACC_W-1:0] rx_acc_imag,
    input  logic                    rx_acc_vld,
    output logic                    tx_lock,
    output logic [1:0]              tx_state,
    output logic                    tx_reacq_req,
    output logic [7:0]              tx_win_cnt
);

    localparam int SUM_W = ACC_W + 8;
    localparam int CMP_W = SUM_W + RATIO_SH;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOCKED = 2'd1,
        ST_LOST   = 2'd2
    } state_t;

    function automatic logic [ACC_W-1:0] sat_abs(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] neg;
        neg = -x;
        if (!x[ACC_W-1])
            return x;
        else if (neg[ACC_W-1])
            return {1'b0, {(ACC_W-1){1'b1}}};
        else
            return neg;
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         pass_cnt_q, pass_cnt_d;
    logic [3:0]         fail_cnt_q, fail_cnt_d;
    logic [7:0]         tmo_cnt_q, tmo_cnt_d;
    logic [7:0]         win_cnt_q, win_cnt_d;
    logic               lock_q, lock_d;
    logic               reacq_q, reacq_d;

    logic [SUM_W-1:0]   sum_i_p0, sum_q_p0;
    logic [7:0]         smp_cnt_p0;
    logic               win_done_p1;

    logic [ACC_W-1:0]   abs_i, abs_q;
    logic [SUM_W-1:0]   base_i, base_q;
    logic [7:0]         base_cnt;
    logic               clr_win, acc_en, win_pass;

    assign abs_i    = sat_abs(rx_acc_real);
    assign abs_q    = sat_abs(rx_acc_imag);
    assign win_pass = CMP_W'(sum_i_p0) > (CMP_W'(sum_q_p0) << RATIO_SH);

    always_comb begin
        state_d    = state_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        win_cnt_d  = win_cnt_q;
        lock_d     = lock_q;
        reacq_d    = 1'b0;
        if (rx_restart) begin
            state_d    = ST_SEARCH;
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            tmo_cnt_d  = '0;
            win_cnt_d  = '0;
            lock_d     = 1'b0;
        end else if (win_done_p1) begin
            if (win_cnt_q != 8'hFF)
                win_cnt_d = win_cnt_q + 8'd1;
            case (state_q)
                ST_SEARCH: begin
                    tmo_cnt_d  = tmo_cnt_q + 8'd1;
                    pass_cnt_d = win_pass ? pass_cnt_q + 4'd1 : 4'd0;
                    // Reaching lock on the timeout window still counts as lock.
                    if (win_pass && (pass_cnt_q + 4'd1 == 4'(LOCK_CNT))) begin
                        state_d    = ST_LOCKED;
                        lock_d     = 1'b1;
                        tmo_cnt_d  = '0;
                        pass_cnt_d = '0;
                    end else if (tmo_cnt_q + 8'd1 == 8'(TMO_WIN)) begin
                        state_d = ST_LOST;
                        reacq_d = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    fail_cnt_d = win_pass ? 4'd0 : fail_cnt_q + 4'd1;
                    if (!win_pass && (fail_cnt_q + 4'd1 == 4'(FAIL_CNT))) begin
                        state_d    = ST_LOST;
                        lock_d     = 1'b0;
                        reacq_d    = 1'b1;
                        fail_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end

        // A completed window or a LOST block restarts integration from zero;
        // a coincident strobe becomes sample 1 unless the block is entering LOST.
        clr_win  = win_done_p1 || (state_d == ST_LOST);
        acc_en   = rx_acc_vld && !rx_restart && (state_d != ST_LOST);
        base_i   = clr_win ? '0 : sum_i_p0;
        base_q   = clr_win ? '0 : sum_q_p0;
        base_cnt = clr_win ? '0 : smp_cnt_p0;
    end

    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            state_q    <= ST_SEARCH;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            win_cnt_q  <= '0;
            lock_q     <= 1'b0;
            reacq_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            win_cnt_q  <= win_cnt_d;
            lock_q     <= lock_d;
            reacq_q    <= reacq_d;
        end
    end

    // Stage p0: window accumulation; stage p1: window-complete flag.
    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            sum_i_p0    <= '0;
            sum_q_p0    <= '0;
            smp_cnt_p0  <= '0;
            win_done_p1 <= 1'b0;
        end else if (rx_restart) begin
            sum_i_p0    <= '0;
            sum_q_p0    <= '0;
            smp_cnt_p0  <= '0;
            win_done_p1 <= 1'b0;
        end else begin
            win_done_p1 <= acc_en && (base_cnt + 8'd1 == 8'(N_INT));
            if (acc_en) begin
                sum_i_p0   <= base_i + SUM_W'(abs_i);
                sum_q_p0   <= base_q + SUM_W'(abs_q);
                smp_cnt_p0 <= base_cnt + 8'd1;
            end else begin
                sum_i_p0   <= base_i;
                sum_q_p0   <= base_q;
                smp_cnt_p0 <= base_cnt;
            end
        end
    end

    assign tx_lock      = lock_q;
    assign tx_state     = state_q;
    assign tx_reacq_req = reacq_q;
    assign tx_win_cnt   = win_cnt_q;

endmodule
